inst_fetch: RTL

// - Instruction fetch stage; sits directly upstream of the memory controller's IF port.
// - Holds the PC and issues word loads on IF_op/IF_len/IF_addr, capturing IF_out on IF_rdy.
// - Hides memory latency with a direct-mapped, one-word-per-line instruction cache.
// - Hands {pc, inst} to decode over a valid/ready handshake and is redirected by EX branches.

---
 rtl/inst_fetch_pkg.sv | 28 ++
 rtl/inst_fetch_icache_dm.sv | 48 ++++
 rtl/inst_fetch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared encodings for the instruction fetch stage and its memory-controller interface.
package inst_fetch_pkg;

  // Memory controller operation codes
  localparam logic [1:0] MEM_NOP  = 2'b00;
  localparam logic [1:0] MEM_LOAD = 2'b01;
  localparam logic [1:0] MEM_SAVE = 2'b10;

  // Memory access widths
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Fetch FSM states
  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StDrop  = 2'd2
  } fetch_state_e;

  // Clear the byte offset of an address
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Lookup is combinational; fills are written on the clock edge.
module inst_fetch_icache_dm #(
  parameter int unsigned IdxW = 6,
  parameter int unsigned TagW = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IdxW-1:0] rd_idx,
  input  logic [TagW-1:0] rd_tag,
  output logic            hit,
  output logic [31:0]     rd_word,
  input  logic            wr_en,
  input  logic [IdxW-1:0] wr_idx,
  input  logic [TagW-1:0] wr_tag,
  input  logic [31:0]     wr_data
);

  localparam int unsigned Lines = 2 ** IdxW;

  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [31:0]      data_q [Lines];

  // Valid bits are the only cache state cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays, written on fill
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Asynchronous read port
  always_comb begin
    hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_word = data_q[rd_idx];
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, miss FSM towards the memory controller, icache and a
// single-entry output buffer towards decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_IDX_W = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        br_en,
  input  logic [31:0] br_target,
  output logic [1:0]  IF_op,
  output logic [1:0]  IF_len,
  output logic [31:0] IF_addr,
  input  logic        IF_rdy,
  input  logic [31:0] IF_out,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int unsigned TagW = 30 - ICACHE_IDX_W;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [1:0]   if_op_q, if_op_d;
  logic [31:0]  if_addr_q, if_addr_d;
  logic         seen_busy_q, seen_busy_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_inst_q, id_inst_d;

  logic         hit;
  logic [31:0]  hit_word;
  logic         fill;
  logic         buf_free;
  logic         done;

  inst_fetch_icache_dm #(
    .IdxW (ICACHE_IDX_W),
    .TagW (TagW)
  ) u_icache (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .rd_idx  (pc_q[ICACHE_IDX_W+1:2]),
    .rd_tag  (pc_q[31:ICACHE_IDX_W+2]),
    .hit     (hit),
    .rd_word (hit_word),
    .wr_en   (fill && rdy_in),
    .wr_idx  (req_addr_q[ICACHE_IDX_W+1:2]),
    .wr_tag  (req_addr_q[31:ICACHE_IDX_W+2]),
    .wr_data (IF_out)
  );

  assign buf_free = !id_valid_q || id_ready;
  // A high IF_rdy only counts once it has been seen low for this request,
  // so the previous request's held level is never mistaken for completion.
  assign done     = seen_busy_q && IF_rdy;

  // Next-state logic for PC, request registers and output buffer
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    if_op_d     = if_op_q;
    if_addr_d   = if_addr_q;
    seen_busy_d = seen_busy_q;
    id_valid_d  = id_valid_q && !id_ready;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    fill        = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (!br_en && buf_free) begin
          if (hit) begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_inst_d  = hit_word;
            pc_d       = pc_q + 32'd4;
          end else begin
            if_op_d     = MEM_LOAD;
            if_addr_d   = word_align(pc_q);
            req_addr_d  = pc_q;
            seen_busy_d = 1'b0;
            state_d     = StWait;
          end
        end
      end
      StWait, StDrop: begin
        seen_busy_d = seen_busy_q || !IF_rdy;
        if (done) begin
          fill    = 1'b1;
          if_op_d = MEM_NOP;
          state_d = StFetch;
          // Buffer is guaranteed empty here: a miss is only issued when it is free
          if (state_q == StWait && !br_en) begin
            id_valid_d = 1'b1;
            id_pc_d    = req_addr_q;
            id_inst_d  = IF_out;
            pc_d       = req_addr_q + 32'd4;
          end
        end else if (br_en) begin
          state_d = StDrop;
        end
      end
      default: state_d = StFetch;
    endcase

    // Redirect wins over hits, handshakes and completions of the same cycle
    if (br_en) begin
      pc_d       = br_target;
      id_valid_d = 1'b0;
    end
  end

  // State registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      req_addr_q  <= ZERO_WORD;
      if_op_q     <= MEM_NOP;
      if_addr_q   <= ZERO_WORD;
      seen_busy_q <= 1'b0;
      id_valid_q  <= 1'b0;
      id_pc_q     <= ZERO_WORD;
      id_inst_q   <= ZERO_WORD;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      if_op_q     <= if_op_d;
      if_addr_q   <= if_addr_d;
      seen_busy_q <= seen_busy_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
    end
  end

  assign IF_op    = if_op_q;
  assign IF_len   = MEM_WORD;
  assign IF_addr  = if_addr_q;
  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

endmodule
